// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for a 32-bit combinational ALU: decodes R-type requests, drives
// registered ALU operands, waits a settle time, then returns the captured result.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_instr,
    input  logic [31:0]      req_rs_val,
    input  logic [31:0]      req_rt_val,
    output logic [31:0]      alu_in0,
    output logic [31:0]      alu_in1,
    output logic [10:0]      alu_op,
    input  logic [31:0]      alu_out,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_carryout,
    output logic             rsp_illegal,
    output logic [4:0]       rsp_rd,
    output logic             rsp_wr_en,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] trap_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [5:0]  funct;
    logic        legal, shamt_op, var_op, accept, is_addsub, rsp_hs;
    logic        unused_fields;

    assign funct         = req_instr[5:0];
    assign unused_fields = ^req_instr[25:16];
    assign req_ready     = (state == IDLE);
    assign accept        = req_valid & req_ready;
    assign rsp_hs        = rsp_valid & rsp_ready;
    assign shamt_op      = (funct == 6'h00) || (funct == 6'h02) || (funct == 6'h03);
    assign var_op        = (funct == 6'h04) || (funct == 6'h06) || (funct == 6'h07);
    // Trap accounting keys off the op still held in alu_op while the response is pending.
    assign is_addsub     = (alu_op[5:0] == 6'h20) || (alu_op[5:0] == 6'h22);

    always_comb begin
        legal = 1'b0;
        if (req_instr[31:26] == 6'd0) begin
            case (funct)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2A, 6'h2B: legal = 1'b1;
                default:                    legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? EXEC : RESP;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            alu_in0      <= '0;
            alu_in1      <= '0;
            alu_op       <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_carryout <= 1'b0;
            rsp_illegal  <= 1'b0;
            rsp_rd       <= '0;
            rsp_wr_en    <= 1'b0;
            op_count     <= '0;
            trap_count   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rsp_rd      <= req_instr[15:11];
                    rsp_illegal <= ~legal;
                    if (legal) begin
                        alu_op  <= {5'b0, funct};
                        alu_in0 <= (shamt_op || var_op) ? req_rt_val : req_rs_val;
                        alu_in1 <= shamt_op ? {27'b0, req_instr[10:6]} :
                                   var_op   ? {27'b0, req_rs_val[4:0]} : req_rt_val;
                        cnt     <= CNT_INIT;
                    end else begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_carryout <= 1'b0;
                        rsp_wr_en    <= 1'b0;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result   <= alu_out;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= alu_zero;
                        rsp_carryout <= alu_carryout;
                        rsp_wr_en    <= (rsp_rd != 5'd0) & ~(is_addsub & alu_overflow);
                        rsp_valid    <= 1'b1;
                    end
                end
                RESP: begin
                    // Illegal requests arrive here with valid still low; raise it one edge later.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != '1) op_count <= op_count + CNT_W'(1);
                        if (~rsp_illegal & rsp_overflow & is_addsub & (trap_count != '1))
                            trap_count <= trap_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 32-bit ALU on the alu_* ports.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_valid3, rsp_ready;
    logic [31:0] req_instr, req_rs_val, req_rt_val;

    logic        req_ready, rsp_valid, rsp_overflow, rsp_zero, rsp_carryout, rsp_illegal, rsp_wr_en;
    logic [31:0] alu_in0, alu_in1, alu_out, rsp_result;
    logic [10:0] alu_op;
    logic        alu_overflow, alu_zero, alu_carryout;
    logic [4:0]  rsp_rd;
    logic [15:0] op_count, trap_count;

    logic        req_ready3, rsp_valid3, rsp_overflow3, rsp_zero3, rsp_carryout3, rsp_illegal3, rsp_wr_en3;
    logic [31:0] alu_in03, alu_in13, alu_out3, rsp_result3;
    logic [10:0] alu_op3;
    logic        alu_overflow3, alu_zero3, alu_carryout3;
    logic [4:0]  rsp_rd3;
    logic [1:0]  op_count3, trap_count3;

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_carryout(rsp_carryout),
        .rsp_illegal(rsp_illegal), .rsp_rd(rsp_rd), .rsp_wr_en(rsp_wr_en),
        .op_count(op_count), .trap_count(trap_count));

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_instr(req_instr), .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
        .alu_in0(alu_in03), .alu_in1(alu_in13), .alu_op(alu_op3), .alu_out(alu_out3),
        .alu_overflow(alu_overflow3), .alu_zero(alu_zero3), .alu_carryout(alu_carryout3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
        .rsp_overflow(rsp_overflow3), .rsp_zero(rsp_zero3), .rsp_carryout(rsp_carryout3),
        .rsp_illegal(rsp_illegal3), .rsp_rd(rsp_rd3), .rsp_wr_en(rsp_wr_en3),
        .op_count(op_count3), .trap_count(trap_count3));

    // Returns {overflow, zero, carryout, result}.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [10:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov, co;
        s = '0; r = '0; ov = 1'b0; co = 1'b0;
        case (op[5:0])
            6'h00, 6'h04: r = a << b[4:0];
            6'h02, 6'h06: r = a >> b[4:0];
            6'h03, 6'h07: r = $unsigned($signed(a) >>> b[4:0]);
            6'h20, 6'h21: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                if (op[5:0] == 6'h20) ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            6'h22, 6'h23: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                if (op[5:0] == 6'h22) ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = {31'b0, $signed(a) < $signed(b)};
            6'h2B: r = {31'b0, a < b};
            default: r = '0;
        endcase
        return {ov, (r == 32'd0), co, r};
    endfunction

    always_comb {alu_overflow, alu_zero, alu_carryout, alu_out} = alu_model(alu_in0, alu_in1, alu_op);
    always_comb {alu_overflow3, alu_zero3, alu_carryout3, alu_out3} = alu_model(alu_in03, alu_in13, alu_op3);

    // Observation mux so the same tasks can drive either instance.
    logic        sel;
    logic        v_req_ready, v_rsp_valid, v_ov, v_zero, v_cout, v_ill, v_wr;
    logic [31:0] v_result, v_in0, v_in1;
    logic [10:0] v_op;
    logic [4:0]  v_rd;
    assign v_req_ready = sel ? req_ready3    : req_ready;
    assign v_rsp_valid = sel ? rsp_valid3    : rsp_valid;
    assign v_result    = sel ? rsp_result3   : rsp_result;
    assign v_ov        = sel ? rsp_overflow3 : rsp_overflow;
    assign v_zero      = sel ? rsp_zero3     : rsp_zero;
    assign v_cout      = sel ? rsp_carryout3 : rsp_carryout;
    assign v_ill       = sel ? rsp_illegal3  : rsp_illegal;
    assign v_rd        = sel ? rsp_rd3       : rsp_rd;
    assign v_wr        = sel ? rsp_wr_en3    : rsp_wr_en;
    assign v_in0       = sel ? alu_in03      : alu_in0;
    assign v_in1       = sel ? alu_in13      : alu_in1;
    assign v_op        = sel ? alu_op3       : alu_op;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Presents one request at posedge+1; returns edges from acceptance to rsp_valid.
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        req_instr = i; req_rs_val = a; req_rt_val = b;
        if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid3 = 1'b0;
        lat = 0;
        while (!v_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!v_rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", v_rsp_valid, 1'b0);
        chk("req_ready_after_hs", v_req_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] instr, rs, rt, res;
        logic        ov, zero, cout, ill;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] in0, in1;
        logic [10:0] op;
    } vec_t;

    vec_t vt[12];
    int   lat;

    initial begin
        //          instr         rs            rt            result        ov  z  co ill rd  wr  in0           in1           op
        vt[0]  = '{32'h00221820, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 0, 0, 3, 0, 32'h7FFFFFFF, 32'h00000001, 11'h20};
        vt[1]  = '{32'h00221004, 32'h00000024, 32'h00000001, 32'h00000010, 0, 0, 0, 0, 2, 1, 32'h00000001, 32'h00000004, 11'h04};
        vt[2]  = '{32'h00222023, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0, 0, 4, 1, 32'h00000005, 32'h00000007, 11'h23};
        vt[3]  = '{32'h00000000, 32'hDEADBEEF, 32'h00001234, 32'h00001234, 0, 0, 0, 0, 0, 0, 32'h00001234, 32'h00000000, 11'h00};
        vt[4]  = '{32'h00022903, 32'h00000000, 32'h80000000, 32'hF8000000, 0, 0, 0, 0, 5, 1, 32'h80000000, 32'h00000004, 11'h03};
        vt[5]  = '{32'h00223022, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1, 0, 6, 0, 32'h80000000, 32'h00000001, 11'h22};
        vt[6]  = '{32'h0022382A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 7, 1, 32'hFFFFFFFF, 32'h00000001, 11'h2A};
        vt[7]  = '{32'h0022382B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 0, 0, 7, 1, 32'hFFFFFFFF, 32'h00000001, 11'h2B};
        vt[8]  = '{32'h00224026, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 0, 0, 0, 0, 8, 1, 32'hA5A5A5A5, 32'hFFFF0000, 11'h26};
        vt[9]  = '{32'h8C000000, 32'h11111111, 32'h22222222, 32'h00000000, 0, 0, 0, 1, 0, 0, 32'hA5A5A5A5, 32'hFFFF0000, 11'h26};
        vt[10] = '{32'h00221801, 32'h33333333, 32'h44444444, 32'h00000000, 0, 0, 0, 1, 3, 0, 32'hA5A5A5A5, 32'hFFFF0000, 11'h26};
        vt[11] = '{32'h00224821, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 1, 0, 9, 1, 32'hFFFFFFFF, 32'h00000001, 11'h21};

        sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0;
        req_instr = '0; req_rs_val = '0; req_rt_val = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_alu_op", alu_op, 11'h0);
        chk("reset_alu_in0", alu_in0, 32'h0);
        chk("reset_op_count", op_count, 16'h0);
        chk("reset_req_ready3", req_ready3, 1'b1);

        for (int k = 0; k < 12; k++) begin
            issue(vt[k].instr, vt[k].rs, vt[k].rt, lat);
            chk($sformatf("v%0d_latency", k), lat, 1);
            chk($sformatf("v%0d_result", k), v_result, vt[k].res);
            chk($sformatf("v%0d_overflow", k), v_ov, vt[k].ov);
            chk($sformatf("v%0d_zero", k), v_zero, vt[k].zero);
            chk($sformatf("v%0d_carry", k), v_cout, vt[k].cout);
            chk($sformatf("v%0d_illegal", k), v_ill, vt[k].ill);
            chk($sformatf("v%0d_rd", k), v_rd, vt[k].rd);
            chk($sformatf("v%0d_wr_en", k), v_wr, vt[k].wr);
            chk($sformatf("v%0d_alu_in0", k), v_in0, vt[k].in0);
            chk($sformatf("v%0d_alu_in1", k), v_in1, vt[k].in1);
            chk($sformatf("v%0d_alu_op", k), v_op, vt[k].op);
            if (k == 0) chk("trap_after_add_ovf", trap_count, 16'd0);
            finish_rsp();
            if (k == 0) chk("trap_count_add", trap_count, 16'd1);
        end
        chk("op_count_table", op_count, 16'd12);
        chk("trap_count_table", trap_count, 16'd2);

        // Response backpressure: everything held, no new request accepted.
        issue(vt[2].instr, vt[2].rs, vt[2].rt, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_result", rsp_result, 32'hFFFFFFFE);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        finish_rsp();
        chk("op_count_hold", op_count, 16'd13);

        // Reset while in EXEC aborts the transaction.
        req_instr = vt[2].instr; req_rs_val = vt[2].rs; req_rt_val = vt[2].rt; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("exec_not_ready", req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_op_count", op_count, 16'd0);
        chk("abort_trap_count", trap_count, 16'd0);
        chk("abort_req_ready", req_ready, 1'b1);
        issue(vt[1].instr, vt[1].rs, vt[1].rt, lat);
        chk("post_abort_latency", lat, 1);
        chk("post_abort_result", rsp_result, 32'h10);
        finish_rsp();
        chk("post_abort_op_count", op_count, 16'd1);

        // Longer settle time and 2-bit counter saturation on the second instance.
        sel = 1'b1;
        issue(vt[11].instr, vt[11].rs, vt[11].rt, lat);
        chk("s3_latency", lat, 3);
        chk("s3_result", v_result, 32'h0);
        chk("s3_zero", v_zero, 1'b1);
        chk("s3_carry", v_cout, 1'b1);
        chk("s3_wr_en", v_wr, 1'b1);
        finish_rsp();
        for (int r = 0; r < 3; r++) begin
            issue(vt[1].instr, vt[1].rs, vt[1].rt, lat);
            finish_rsp();
        end
        chk("s3_op_count_sat", op_count3, 2'b11);
        chk("s3_trap_count", trap_count3, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
